cdb_arbiter: RTL and testbench

//  Common-data-bus arbiter for the Tomasulo core. Collects results from the NUM_FU

---
 rtl/cdb_arbiter.sv | 130 +++++++++++++
 tb/tb_cdb_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter for the Tomasulo core.
// Each functional unit owns one holding slot. One full slot per cycle is chosen
// round-robin and broadcast on a registered tag+data bus. FU index i uses tag i+1,
// because tag 0 means "value present".
module cdb_arbiter #(
    parameter int NUM_FU = 7,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [NUM_FU-1:0]        rs_release
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [PTR_W:0]   NUM_FU_EXT = (PTR_W + 1)'(NUM_FU);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_FU - 1);

    // Tags 1..NUM_FU must fit in TAG_W bits with 0 left reserved.
    generate
        if (NUM_FU > (2 ** TAG_W) - 1) begin : g_tag_space_check
            $error("cdb_arbiter: NUM_FU does not fit in the tag space");
        end
    endgenerate

    logic [NUM_FU-1:0] slot_full;
    logic [DATA_W-1:0] slot_data [NUM_FU];
    logic [NUM_FU-1:0] grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    logic [PTR_W:0]    probe;
    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [PTR_W-1:0]  rr_ptr_next;

    logic              cdb_valid_reg;
    logic [TAG_W-1:0]  cdb_tag_reg;
    logic [DATA_W-1:0] cdb_data_reg;
    logic [NUM_FU-1:0] rs_release_reg;

    // One holding slot per FU. A slot being granted this cycle can be refilled
    // in the same cycle, so a lone streaming FU never sees backpressure.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_slot
            logic              full_reg;
            logic [DATA_W-1:0] data_reg;

            // Slot occupancy: flush beats load, load beats drain.
            always_ff @(posedge CLOCK_50 or posedge RESET) begin
                if (RESET) begin
                    full_reg <= 1'b0;
                    data_reg <= '0;
                end else if (flush) begin
                    full_reg <= 1'b0;
                end else if (fu_valid[gi] && fu_ready[gi]) begin
                    full_reg <= 1'b1;
                    data_reg <= fu_data[gi*DATA_W +: DATA_W];
                end else if (grant[gi]) begin
                    full_reg <= 1'b0;
                end
            end

            assign slot_full[gi] = full_reg;
            assign slot_data[gi] = data_reg;
            assign fu_ready[gi]  = !flush && (!full_reg || grant[gi]);
        end
    endgenerate

    // Round-robin search starting at rr_ptr; first full slot wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        probe     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            probe = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(k);
            if (probe >= NUM_FU_EXT) begin
                probe = probe - NUM_FU_EXT;
            end
            if (!grant_any && slot_full[probe[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = probe[PTR_W-1:0];
            end
        end
        grant[grant_idx] = grant_any;
    end

    // Pointer moves just past the winner so it becomes lowest priority next.
    always_comb begin
        rr_ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
    end

    // Broadcast register and round-robin pointer; fu_* never reaches cdb_* combinationally.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cdb_valid_reg  <= 1'b0;
            cdb_tag_reg    <= '0;
            cdb_data_reg   <= '0;
            rs_release_reg <= '0;
            rr_ptr_reg     <= '0;
        end else if (flush) begin
            cdb_valid_reg  <= 1'b0;
            cdb_tag_reg    <= '0;
            cdb_data_reg   <= '0;
            rs_release_reg <= '0;
            rr_ptr_reg     <= '0;
        end else begin
            cdb_valid_reg  <= grant_any;
            cdb_tag_reg    <= grant_any ? TAG_W'(grant_idx) + TAG_W'(1) : '0;
            cdb_data_reg   <= grant_any ? slot_data[grant_idx] : '0;
            rs_release_reg <= grant;
            if (grant_any) begin
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

    assign cdb_valid  = cdb_valid_reg;
    assign cdb_tag    = cdb_tag_reg;
    assign cdb_data   = cdb_data_reg;
    assign rs_release = rs_release_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a slot/pointer model of the arbiter.
module tb_cdb_arbiter;

    localparam int NUM_FU = 7;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 3;

    logic                     CLOCK_50 = 1'b0;
    logic                     RESET;
    logic                     flush;
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [NUM_FU-1:0]        rs_release;

    int n_checks = 0;
    int n_fail   = 0;
    bit verbose  = 1'b1;

    cdb_arbiter #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .flush      (flush),
        .fu_valid   (fu_valid),
        .fu_data    (fu_data),
        .fu_ready   (fu_ready),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .rs_release (rs_release)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_fu(input int i, input logic [DATA_W-1:0] d);
        fu_data[i*DATA_W +: DATA_W] = d;
    endtask

    // ---------------- reference model ----------------
    bit                m_full [NUM_FU];
    logic [DATA_W-1:0] m_data [NUM_FU];
    int                m_ptr;
    bit                e_valid;
    int                e_tag;
    logic [DATA_W-1:0] e_data;
    logic [NUM_FU-1:0] e_rel;
    bit                e_after_flush;

    function automatic int pick();
        for (int k = 0; k < NUM_FU; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_FU;
            if (m_full[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_FU; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = '0;
        end
        m_ptr = 0;
        e_valid = 1'b0;
        e_tag = 0;
        e_data = '0;
        e_rel = '0;
        e_after_flush = 1'b0;
    endtask

    task automatic model_step();
        int g;
        bit rdy [NUM_FU];
        g = pick();
        if (flush) begin
            for (int i = 0; i < NUM_FU; i++) m_full[i] = 1'b0;
            m_ptr = 0;
            e_valid = 1'b0;
            e_tag = 0;
            e_data = '0;
            e_rel = '0;
            e_after_flush = 1'b1;
        end else begin
            e_after_flush = 1'b0;
            for (int i = 0; i < NUM_FU; i++) rdy[i] = !m_full[i] || (g == i);
            e_valid = (g >= 0);
            e_tag   = (g >= 0) ? g + 1 : 0;
            e_data  = (g >= 0) ? m_data[g] : '0;
            e_rel   = (g >= 0) ? (NUM_FU'(1) << g) : '0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && rdy[i]) begin
                    m_full[i] = 1'b1;
                    m_data[i] = fu_data[i*DATA_W +: DATA_W];
                end else if (g == i) begin
                    m_full[i] = 1'b0;
                end
            end
            if (g >= 0) m_ptr = (g + 1) % NUM_FU;
        end
    endtask

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin : compare_proc
        int g;
        logic [NUM_FU-1:0] exp_rdy;
        model_clear();
        forever begin
            @(negedge CLOCK_50);
            if (RESET) model_clear();
            g = pick();
            for (int i = 0; i < NUM_FU; i++) exp_rdy[i] = !flush && (!m_full[i] || g == i);
            check("model cdb_valid", 64'(cdb_valid), 64'(e_valid));
            check("model rs_release", 64'(rs_release), 64'(e_rel));
            check("model fu_ready", 64'(fu_ready), 64'(exp_rdy));
            if (!e_after_flush) begin
                check("model cdb_tag", 64'(cdb_tag), 64'(e_tag));
                check("model cdb_data", 64'(cdb_data), 64'(e_data));
            end
            if (verbose && cdb_valid)
                $display("cdb broadcast tag=%0d data=0x%08h release=%b t=%0t",
                         cdb_tag, cdb_data, rs_release, $time);
            @(posedge CLOCK_50);
            if (RESET) model_clear();
            else model_step();
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int exp_tags [3];
        int exp_dat  [3];
        logic [DATA_W-1:0] bq [$];
        bit saw_block;
        bit b_acc;
        bit rdy1;
        logic [NUM_FU-1:0] acc;
        int load;

        RESET    = 1'b1;
        flush    = 1'b0;
        fu_valid = '0;
        fu_data  = '0;
        repeat (3) step();
        RESET = 1'b0;
        @(negedge CLOCK_50);
        check("reset fu_ready", 64'(fu_ready), 64'h7F);
        check("reset cdb_valid", 64'(cdb_valid), 64'h0);

        // Single result from FU2.
        step();
        fu_valid = 7'b0000100;
        set_fu(2, 32'h0000_0005);
        step();
        fu_valid = '0;
        step();
        @(negedge CLOCK_50);
        check("single valid", 64'(cdb_valid), 64'h1);
        check("single tag", 64'(cdb_tag), 64'h3);
        check("single data", 64'(cdb_data), 64'h5);
        check("single release", 64'(rs_release), 64'b0000100);
        step();
        @(negedge CLOCK_50);
        check("single idle after", 64'(cdb_valid), 64'h0);

        // Round-robin from rr_ptr=0 (flush resets the pointer).
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        fu_valid = 7'b1001001;
        set_fu(0, 32'h10);
        set_fu(3, 32'h13);
        set_fu(6, 32'h16);
        step();
        fu_valid = '0;
        exp_tags = '{1, 4, 7};
        exp_dat  = '{32'h10, 32'h13, 32'h16};
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge CLOCK_50);
            check("rr tag", 64'(cdb_tag), 64'(exp_tags[k]));
            check("rr data", 64'(cdb_data), 64'(exp_dat[k]));
        end
        // Pointer must be back at 0: FU1 then FU6.
        step();
        fu_valid = 7'b1000010;
        set_fu(1, 32'h21);
        set_fu(6, 32'h26);
        step();
        fu_valid = '0;
        step();
        @(negedge CLOCK_50);
        check("rr wrap first tag", 64'(cdb_tag), 64'h2);
        step();
        @(negedge CLOCK_50);
        check("rr wrap second tag", 64'(cdb_tag), 64'h7);

        // Backpressure on FU1 while FU0 and FU2 are also full.
        step();
        fu_valid = 7'b0000111;
        set_fu(0, 32'h100);
        set_fu(1, 32'hA);
        set_fu(2, 32'h200);
        step();
        fu_valid = 7'b0000010;
        set_fu(1, 32'hB);
        saw_block = 1'b0;
        b_acc = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLOCK_50);
            if (cdb_valid && cdb_tag == 3'd2) bq.push_back(cdb_data);
            rdy1 = fu_ready[1];
            if (!rdy1 && !b_acc) saw_block = 1'b1;
            step();
            if (fu_valid[1] && rdy1) begin
                b_acc = 1'b1;
                fu_valid[1] = 1'b0;
            end
        end
        check("bp saw fu_ready low", 64'(saw_block), 64'h1);
        check("bp 0xB accepted", 64'(b_acc), 64'h1);
        check("bp tag2 count", 64'(bq.size()), 64'h2);
        if (bq.size() >= 2) begin
            check("bp first", 64'(bq[0]), 64'hA);
            check("bp second", 64'(bq[1]), 64'hB);
        end

        // FU4 streaming alone.
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 12; k++) begin
            fu_valid = (k < 10) ? 7'b0010000 : 7'b0000000;
            set_fu(4, 32'h5000 + k);
            @(negedge CLOCK_50);
            check("stream ready4", 64'(fu_ready[4]), 64'h1);
            if (k >= 2) begin
                check("stream valid", 64'(cdb_valid), 64'h1);
                check("stream tag", 64'(cdb_tag), 64'h5);
                check("stream data", 64'(cdb_data), 64'(32'h5000 + k - 2));
            end
            step();
        end
        fu_valid = '0;

        // Flush with four slots full and a broadcast in flight.
        step();
        fu_valid = 7'b0001000;
        set_fu(3, 32'h33);
        step();
        fu_valid = 7'b1100011;
        set_fu(0, 32'h60);
        set_fu(1, 32'h61);
        set_fu(5, 32'h65);
        set_fu(6, 32'h66);
        step();
        fu_valid = '0;
        flush = 1'b1;
        @(negedge CLOCK_50);
        check("preflush valid", 64'(cdb_valid), 64'h1);
        check("preflush tag", 64'(cdb_tag), 64'h4);
        check("flush fu_ready", 64'(fu_ready), 64'h0);
        step();
        flush = 1'b0;
        @(negedge CLOCK_50);
        check("postflush valid", 64'(cdb_valid), 64'h0);
        check("postflush release", 64'(rs_release), 64'h0);
        check("postflush ready", 64'(fu_ready), 64'h7F);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge CLOCK_50);
            check("no flushed tag", 64'(cdb_valid), 64'h0);
        end
        step();
        fu_valid = 7'b0000100;
        set_fu(2, 32'h77);
        step();
        fu_valid = '0;
        step();
        @(negedge CLOCK_50);
        check("after flush valid", 64'(cdb_valid), 64'h1);
        check("after flush tag", 64'(cdb_tag), 64'h3);
        check("after flush data", 64'(cdb_data), 64'h77);

        // Reset mid-stream with three slots pending and a broadcast on the bus.
        step();
        fu_valid = 7'b0001111;
        set_fu(0, 32'h90);
        set_fu(1, 32'h91);
        set_fu(2, 32'h92);
        set_fu(3, 32'h93);
        step();
        fu_valid = '0;
        step();
        @(negedge CLOCK_50);
        check("prereset valid", 64'(cdb_valid), 64'h1);
        #2;
        RESET = 1'b1;
        #1;
        check("reset mid valid", 64'(cdb_valid), 64'h0);
        check("reset mid tag", 64'(cdb_tag), 64'h0);
        check("reset mid data", 64'(cdb_data), 64'h0);
        check("reset mid release", 64'(rs_release), 64'h0);
        step();
        RESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLOCK_50);
            check("post reset ready", 64'(fu_ready), 64'h7F);
            check("post reset no spurious", 64'(cdb_valid), 64'h0);
            step();
        end

        // Randomized traffic with FUs honouring the hold rule.
        verbose = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge CLOCK_50);
            acc = fu_valid & fu_ready;
            step();
            flush = ($urandom_range(39) == 0);
            if (RESET) RESET = 1'b0;
            else if ($urandom_range(399) == 0) RESET = 1'b1;
            case ((cyc / 500) % 4)
                0: load = 20;
                1: load = 50;
                2: load = 90;
                default: load = 100;
            endcase
            for (int i = 0; i < NUM_FU; i++) begin
                if (!fu_valid[i] || acc[i]) begin
                    fu_valid[i] = ($urandom_range(99) < load);
                    set_fu(i, $urandom);
                end
            end
        end
        RESET = 1'b0;
        flush = 1'b0;
        fu_valid = '0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
